adc_scan_ctrl: RTL and testbench
================================

# adc_scan_ctrl

Transaction scheduler for the I2C ADC read engine. It periodically sweeps a fixed set of ADC channels and keeps the latest result per channel in a register bank that the display and SPI paths read directly. It also shares the engine with one on-demand host requester (SPI command path), granting one engine transaction at a time. It sits between the engine's request/data handshake and the display/SPI logic, replacing the tie-high `rd_req` usage.

## Interface
Parameters:
- `CH_NUM`, 4: channels swept per scan; range 1..8.
- `SCAN_DIV`, 500_000: sys_clk cycles between scan ticks; must be ≥ 2.
- `TIMEOUT`, 100_000: maximum sys_clk cycles spent waiting for engine data.
- `CTRL_BASE`, 8'h40: engine register address for channel 0. Channel n uses `CTRL_BASE + n`.

Ports:
- `sys_clk` — in, 1: system clock.
- `sys_rst_n` — in, 1: reset, asynchronous assert, active-low.
- `eng_rd_req` — out, 1: one-cycle pulse that starts one engine read.
- `eng_reg_addr` — out, 8: register address, held from request until completion.
- `eng_rd_data` — in, 8: engine read data.
- `eng_rd_data_vld` — in, 1: one-cycle pulse that qualifies `eng_rd_data`.
- `host_req` — in, 1: level; held high until `host_ack`.
- `host_addr` — in, 8: register address; stable while `host_req` is high.
- `host_ack` — out, 1: one-cycle completion pulse.
- `host_data` — out, 8: host result, valid with `host_ack`.
- `host_err` — out, 1: timeout indicator, valid with `host_ack`.
- `ch_data` — out, CH_NUM*8: result bank; channel n occupies bits [8n+7:8n].
- `ch_vld` — out, CH_NUM: per-channel sticky "updated at least once" flag.
- `ch_tmo` — out, CH_NUM: per-channel sticky timeout flag.
- `scan_done` — out, 1: one-cycle pulse after the last channel of a scan is stored.
- `overrun` — out, 1: sticky; a scan tick arrived while a scan was in progress.
- `busy` — out, 1: high whenever the FSM is not in IDLE.

## Operation
- Every output resets to 0. The FSM resets to IDLE, the channel index to 0, and the tick counter to 0.
- The tick counter runs 0..SCAN_DIV-1 and wraps. The tick fires on the cycle the counter equals SCAN_DIV-1.
- A tick while no scan is pending sets `scan_pend` and the channel index to 0.
- A tick while a scan is pending is dropped and sets `overrun`.
- FSM states:
  - IDLE to REQ, when `host_req` is high and not yet acknowledged (host is granted), or when `scan_pend` is high (scan is granted).
  - Host has priority at every IDLE decision. There is no preemption: a transaction in flight always completes.
  - REQ: assert `eng_rd_req` for one cycle, then go to WAIT. The wait counter starts at 0.
  - WAIT: on `eng_rd_data_vld`, go to STORE. If the wait counter reaches TIMEOUT-1 without data, go to STORE with the timeout flag set.
  - STORE (one cycle), for a host grant: drive `host_ack`=1 and `host_data`. On timeout, `host_data`=8'hFF and `host_err`=1. Scan state is untouched.
  - STORE (one cycle), for a scan grant, with data: write `ch_data[idx]`, set `ch_vld[idx]`.
  - STORE, for a scan grant, on timeout: leave `ch_data[idx]` unchanged and set `ch_tmo[idx]`.
  - STORE, for a scan grant, always: increment `idx`. If `idx` was CH_NUM-1, clear `scan_pend`, pulse `scan_done`, and return `idx` to 0.
  - After STORE, return to IDLE.
- A host request arriving mid-scan is served between two scan channels. The scan then resumes at the same `idx`.
- `eng_rd_data_vld` outside WAIT is ignored.
- Asserting reset mid-transaction aborts immediately. The engine shares `sys_rst_n`, so no recovery sequencing is needed.

## Timing
- `host_req` rises while IDLE with no scan pending: REQ on cycle +1, with `eng_rd_req`=1 and `eng_reg_addr`=`host_addr`.
- Data pulse in cycle k: STORE in k+1, so `ch_data`/`host_ack` update at the k+1 clock edge. IDLE follows in k+2.
- Minimum transaction length is 4 cycles (IDLE, REQ, WAIT, STORE).
- A timeout transaction is exactly TIMEOUT WAIT cycles followed by STORE.
- `host_req` must drop in the cycle after `host_ack`. A still-high `host_req` in that IDLE cycle is treated as a new request.
- Tick and STORE of the last channel in the same cycle: the scan completes, and the tick starts a new scan (`scan_pend` set). There is no overrun in this case.

## Configuration
- `ADC_SCAN_AVG_EN` defined: a scan STORE with data writes `(old + new + 1) >> 1`, computed at 9-bit width. The first sample of a channel (`ch_vld[idx]`=0) is stored raw.
- `ADC_SCAN_AVG_EN` undefined: the raw sample is stored. Host data is never averaged in either case.

## Structure
- Package `adc_scan_pkg` holds the FSM state enum (IDLE, REQ, WAIT, STORE), the timeout fill value 8'hFF, and the default parameter constants.
- One sub-module, `scan_tick_gen`: a parameterized SCAN_DIV counter that outputs the single-cycle tick.

## Test plan
Bench parameters: CH_NUM=4, SCAN_DIV=200, TIMEOUT=50, CTRL_BASE=8'h40; the engine model returns data 3 cycles after the request.
- Scan sweep: engine returns {8'h10, 8'h20, 8'h30, 8'h40} for addresses 40..43. Expect `ch_data`=32'h40302010, `ch_vld`=4'hF, and `scan_done` pulsed once.
- Host priority: raise `host_req` with `host_addr`=8'h7A during channel 1's WAIT. Expect channel 1 to complete, then a request at 7A with `host_ack` and `host_data` as returned, then a request at 42.
- Timeout: the engine never answers address 42. Expect exactly 50 WAIT cycles, `ch_tmo`=4'b0100, `ch_data[2]` unchanged, and the scan continuing at 43.
- Overrun: the engine answers after 60 cycles. Expect the second tick to set `overrun` and every scan to still visit 40..43 in order.
- Averaging (macro on): channel 0 samples 8'h10 then 8'h13. Expect 8'h10, then 8'h12.
- Reset mid-WAIT: all outputs return to 0 and the first post-reset request is at address 40 after the first tick.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// Shared definitions for the ADC scan scheduler.
//   - scan_state_e : scheduler FSM states
//   - TMO_FILL     : host result returned when the engine never answers
//   - DEF_*        : default parameter values
//   - avg_round    : rounded two-sample mean, used when ADC_SCAN_AVG_EN is defined
package adc_scan_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StStore
  } scan_state_e;

  localparam logic [7:0]  TMO_FILL      = 8'hFF;
  localparam int unsigned DEF_CH_NUM    = 4;
  localparam int unsigned DEF_SCAN_DIV  = 500_000;
  localparam int unsigned DEF_TIMEOUT   = 100_000;
  localparam logic [7:0]  DEF_CTRL_BASE = 8'h40;

  // (a + b + 1) >> 1 evaluated at 9 bits so the carry is kept.
  function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return sum[8:1];
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running scan period counter.
// Counts 0..SCAN_DIV-1 and wraps; o_tick is high for the single cycle in which
// the counter equals SCAN_DIV-1.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   o_tick  - one-cycle scan tick
module scan_tick_gen
  import adc_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned      CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/adc_scan_ctrl.sv
// ADC scan scheduler: shares one I2C ADC read engine between a periodic channel
// sweep and a single on-demand host requester, one transaction at a time.
// Optional feature: define ADC_SCAN_AVG_EN to store the rounded mean of the old
// and new sample for scan channels (first sample of a channel stored raw).
// Ports:
//   sys_clk, sys_rst_n          - clock, asynchronous active-low reset
//   eng_rd_req / eng_reg_addr   - engine read pulse and held register address
//   eng_rd_data / _vld          - engine result and its qualifying pulse
//   host_req / host_addr        - host level request and address
//   host_ack / host_data / _err - host completion pulse, result, timeout flag
//   ch_data / ch_vld / ch_tmo   - per-channel result bank and sticky flags
//   scan_done                   - pulse while the last channel of a scan is stored
//   overrun                     - sticky: tick arrived while a scan was pending
//   busy                        - FSM not idle
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int unsigned CH_NUM    = DEF_CH_NUM,
  parameter int unsigned SCAN_DIV  = DEF_SCAN_DIV,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter logic [7:0]  CTRL_BASE = DEF_CTRL_BASE
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  output logic                  eng_rd_req,
  output logic [7:0]            eng_reg_addr,
  input  logic [7:0]            eng_rd_data,
  input  logic                  eng_rd_data_vld,
  input  logic                  host_req,
  input  logic [7:0]            host_addr,
  output logic                  host_ack,
  output logic [7:0]            host_data,
  output logic                  host_err,
  output logic [CH_NUM*8-1:0]   ch_data,
  output logic [CH_NUM-1:0]     ch_vld,
  output logic [CH_NUM-1:0]     ch_tmo,
  output logic                  scan_done,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned       IDX_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CH_NUM - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  scan_state_e         r_state;
  logic                r_grant_host;
  logic                r_scan_pend;
  logic [IDX_W-1:0]    r_idx;
  logic [WAIT_W-1:0]   r_wait_cnt;

  logic                r_eng_rd_req;
  logic [7:0]          r_eng_reg_addr;
  logic                r_host_ack;
  logic [7:0]          r_host_data;
  logic                r_host_err;
  logic [CH_NUM*8-1:0] r_ch_data;
  logic [CH_NUM-1:0]   r_ch_vld;
  logic [CH_NUM-1:0]   r_ch_tmo;
  logic                r_scan_done;
  logic                r_overrun;

  logic                w_tick;
  logic                w_wait_done;
  logic                w_tmo;
  logic                w_scan_last;
  logic [7:0]          w_scan_addr;
  logic [7:0]          w_ch_new;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .o_tick  (w_tick)
  );

  assign w_scan_addr = CTRL_BASE + 8'(r_idx);
  assign w_wait_done = eng_rd_data_vld || (r_wait_cnt == WAIT_LAST);
  // Data arriving on the final wait cycle wins over the timeout.
  assign w_tmo       = !eng_rd_data_vld;
  // Last channel leaving STORE this cycle: a coincident tick restarts the scan.
  assign w_scan_last = (r_state == StStore) && !r_grant_host && (r_idx == LAST_IDX);

`ifdef ADC_SCAN_AVG_EN
  logic [7:0] w_ch_old;
  assign w_ch_old = r_ch_data[{r_idx, 3'b000} +: 8];
  assign w_ch_new = r_ch_vld[r_idx] ? avg_round(w_ch_old, eng_rd_data) : eng_rd_data;
`else
  assign w_ch_new = eng_rd_data;
`endif

  // Result registers are written on entry to STORE so they are visible during the
  // STORE cycle; the scan index advances on exit from STORE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state        <= StIdle;
      r_grant_host   <= 1'b0;
      r_scan_pend    <= 1'b0;
      r_idx          <= '0;
      r_wait_cnt     <= '0;
      r_eng_rd_req   <= 1'b0;
      r_eng_reg_addr <= '0;
      r_host_ack     <= 1'b0;
      r_host_data    <= '0;
      r_host_err     <= 1'b0;
      r_ch_data      <= '0;
      r_ch_vld       <= '0;
      r_ch_tmo       <= '0;
      r_scan_done    <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_eng_rd_req <= 1'b0;
      r_host_ack   <= 1'b0;
      r_host_err   <= 1'b0;
      r_scan_done  <= 1'b0;

      unique case (r_state)
        StIdle: begin
          // Host wins every idle decision; the scan resumes at r_idx afterwards.
          if (host_req) begin
            r_grant_host   <= 1'b1;
            r_eng_reg_addr <= host_addr;
            r_eng_rd_req   <= 1'b1;
            r_state        <= StReq;
          end else if (r_scan_pend) begin
            r_grant_host   <= 1'b0;
            r_eng_reg_addr <= w_scan_addr;
            r_eng_rd_req   <= 1'b1;
            r_state        <= StReq;
          end
        end

        StReq: begin
          r_wait_cnt <= '0;
          r_state    <= StWait;
        end

        StWait: begin
          if (w_wait_done) begin
            r_state <= StStore;
            if (r_grant_host) begin
              r_host_ack  <= 1'b1;
              r_host_data <= w_tmo ? TMO_FILL : eng_rd_data;
              r_host_err  <= w_tmo;
            end else begin
              if (w_tmo) begin
                r_ch_tmo[r_idx] <= 1'b1;
              end else begin
                r_ch_data[{r_idx, 3'b000} +: 8] <= w_ch_new;
                r_ch_vld[r_idx]                 <= 1'b1;
              end
              r_scan_done <= (r_idx == LAST_IDX);
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end

        StStore: begin
          if (!r_grant_host) begin
            if (r_idx == LAST_IDX) begin
              r_scan_pend <= 1'b0;
              r_idx       <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
          r_state <= StIdle;
        end

        default: r_state <= StIdle;
      endcase

      // Placed after the FSM so a tick overrides the end-of-scan clear.
      if (w_tick) begin
        if (!r_scan_pend || w_scan_last) begin
          r_scan_pend <= 1'b1;
          r_idx       <= '0;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign eng_rd_req   = r_eng_rd_req;
  assign eng_reg_addr = r_eng_reg_addr;
  assign host_ack     = r_host_ack;
  assign host_data    = r_host_data;
  assign host_err     = r_host_err;
  assign ch_data      = r_ch_data;
  assign ch_vld       = r_ch_vld;
  assign ch_tmo       = r_ch_tmo;
  assign scan_done    = r_scan_done;
  assign overrun      = r_overrun;
  assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with a simple engine model that answers a
// programmable number of cycles after each request (or never, for a muted address).
module tb_adc_scan_ctrl;

  localparam int unsigned CH_NUM    = 4;
  localparam int unsigned SCAN_DIV  = 200;
  localparam int unsigned TIMEOUT   = 50;
  localparam logic [7:0]  CTRL_BASE = 8'h40;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        eng_rd_req;
  logic [7:0]  eng_reg_addr;
  logic [7:0]  eng_rd_data = 8'h00;
  logic        eng_rd_data_vld = 1'b0;
  logic        host_req = 1'b0;
  logic [7:0]  host_addr = 8'h00;
  logic        host_ack;
  logic [7:0]  host_data;
  logic        host_err;
  logic [31:0] ch_data;
  logic [3:0]  ch_vld;
  logic [3:0]  ch_tmo;
  logic        scan_done;
  logic        overrun;
  logic        busy;

  int total = 0;
  int bad = 0;

  adc_scan_ctrl #(
    .CH_NUM    (CH_NUM),
    .SCAN_DIV  (SCAN_DIV),
    .TIMEOUT   (TIMEOUT),
    .CTRL_BASE (CTRL_BASE)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .eng_rd_req      (eng_rd_req),
    .eng_reg_addr    (eng_reg_addr),
    .eng_rd_data     (eng_rd_data),
    .eng_rd_data_vld (eng_rd_data_vld),
    .host_req        (host_req),
    .host_addr       (host_addr),
    .host_ack        (host_ack),
    .host_data       (host_data),
    .host_err        (host_err),
    .ch_data         (ch_data),
    .ch_vld          (ch_vld),
    .ch_tmo          (ch_tmo),
    .scan_done       (scan_done),
    .overrun         (overrun),
    .busy            (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Engine model, driven on the falling edge.
  int         eng_delay = 3;
  logic       mute_en = 1'b0;
  logic [7:0] mute_addr = 8'h00;
  logic [7:0] mem [256];
  int         eng_cnt = 0;
  logic [7:0] eng_cur = 8'h00;
  int         stray_req = 0;
  int         stray_ack = 0;

  always @(negedge sys_clk) begin
    eng_rd_data_vld = 1'b0;
    if (!sys_rst_n) begin
      eng_cnt = 0;
    end else if (eng_rd_req) begin
      eng_cnt = eng_delay;
      eng_cur = eng_reg_addr;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && !(mute_en && eng_cur == mute_addr)) begin
        eng_rd_data_vld = 1'b1;
        eng_rd_data     = mem[eng_cur];
      end
    end else if (stray_req != stray_ack) begin
      stray_ack++;
      eng_rd_data_vld = 1'b1;
      eng_rd_data     = 8'hEE;
    end
  end

  // Request / completion log.
  int         cyc = 0;
  logic [7:0] req_addr[$];
  int         req_cyc[$];
  int         done_cnt = 0;

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (sys_rst_n && eng_rd_req) begin
      req_addr.push_back(eng_reg_addr);
      req_cyc.push_back(cyc);
    end
    if (scan_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // sel: 0 eng_rd_req, 1 scan_done, 2 host_ack, 3 overrun. n = -1 if the bound expires.
  task automatic wait_cond(input int sel, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge sys_clk);
      if ((sel == 0 && eng_rd_req) || (sel == 1 && scan_done) ||
          (sel == 2 && host_ack) || (sel == 3 && overrun)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_rd_req"}, 64'(eng_rd_req), 64'd0);
    chk({pfx, "_reg_addr"}, 64'(eng_reg_addr), 64'd0);
    chk({pfx, "_host_ack"}, 64'(host_ack), 64'd0);
    chk({pfx, "_host_data"}, 64'(host_data), 64'd0);
    chk({pfx, "_host_err"}, 64'(host_err), 64'd0);
    chk({pfx, "_ch_data"}, 64'(ch_data), 64'd0);
    chk({pfx, "_ch_vld"}, 64'(ch_vld), 64'd0);
    chk({pfx, "_ch_tmo"}, 64'(ch_tmo), 64'd0);
    chk({pfx, "_scan_done"}, 64'(scan_done), 64'd0);
    chk({pfx, "_overrun"}, 64'(overrun), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] pack_addrs(input int first, input int cnt);
    logic [63:0] v = '0;
    for (int i = first; i < first + cnt; i++) begin
      if (i < req_addr.size()) v = {v[55:0], req_addr[i]};
      else v = {v[55:0], 8'hXX};
    end
    return v;
  endfunction

  initial begin
    int n;
    int base;
    logic [7:0] avg_exp;
`ifdef ADC_SCAN_AVG_EN
    avg_exp = 8'h12;
`else
    avg_exp = 8'h13;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h40] = 8'h10;
    mem[8'h41] = 8'h20;
    mem[8'h42] = 8'h30;
    mem[8'h43] = 8'h40;
    mem[8'h55] = 8'hA5;
    mem[8'h7A] = 8'h5C;

    // Reset state.
    repeat (3) @(negedge sys_clk);
    chk_zero("rst");

    // First tick: pend set after 200 edges, request on edge 201.
    sys_rst_n = 1'b1;
    wait_cond(0, 400, n);
    chk("first_req_lat", 64'(n), 64'd201);
    chk("first_req_addr", 64'(eng_reg_addr), 64'h40);
    chk("busy_in_req", 64'(busy), 64'd1);

    // Scan sweep.
    wait_cond(1, 100, n);
    chk("sweep_done_seen", 64'(n > 0), 64'd1);
    chk("sweep_ch_data", 64'(ch_data), 64'h40302010);
    chk("sweep_ch_vld", 64'(ch_vld), 64'hF);
    chk("sweep_ch_tmo", 64'(ch_tmo), 64'h0);
    repeat (20) @(negedge sys_clk);
    chk("sweep_done_cnt", 64'(done_cnt), 64'd1);
    chk("sweep_addrs", pack_addrs(0, 4), 64'h40414243);
    chk("sweep_req_gap", 64'(req_cyc[1] - req_cyc[0]), 64'd6);
    chk("sweep_busy_idle", 64'(busy), 64'd0);

    // Host request while idle: REQ next cycle, ack 4 cycles later.
    host_addr = 8'h55;
    host_req  = 1'b1;
    wait_cond(0, 5, n);
    chk("host_req_lat", 64'(n), 64'd1);
    chk("host_req_addr", 64'(eng_reg_addr), 64'h55);
    wait_cond(2, 20, n);
    chk("host_ack_lat", 64'(n), 64'd4);
    chk("host_data", 64'(host_data), 64'hA5);
    chk("host_err_ok", 64'(host_err), 64'd0);
    host_req = 1'b0;
    @(negedge sys_clk);
    chk("host_ack_pulse", 64'(host_ack), 64'd0);

    // Host timeout: REQ, 50 WAIT cycles, STORE.
    mute_en   = 1'b1;
    mute_addr = 8'h99;
    host_addr = 8'h99;
    host_req  = 1'b1;
    wait_cond(2, 100, n);
    chk("host_tmo_lat", 64'(n), 64'd52);
    chk("host_tmo_data", 64'(host_data), 64'hFF);
    chk("host_tmo_err", 64'(host_err), 64'd1);
    host_req = 1'b0;
    mute_en  = 1'b0;

    // Host priority mid-scan.
    mem[8'h41] = 8'h21;
    req_addr.delete();
    req_cyc.delete();
    wait_cond(0, 200, n);
    chk("prio_req0", 64'(eng_reg_addr), 64'h40);
    wait_cond(0, 20, n);
    chk("prio_req1", 64'(eng_reg_addr), 64'h41);
    @(negedge sys_clk);
    host_addr = 8'h7A;
    host_req  = 1'b1;
    wait_cond(2, 40, n);
    chk("prio_ack_seen", 64'(n > 0), 64'd1);
    chk("prio_host_data", 64'(host_data), 64'h5C);
    host_req = 1'b0;
    wait_cond(1, 60, n);
    chk("prio_done_seen", 64'(n > 0), 64'd1);
    repeat (3) @(negedge sys_clk);
    chk("prio_addrs", pack_addrs(0, 5), 64'h40417A4243);
    chk("prio_ch_data", 64'(ch_data), 64'h40302110);

    // Timeout on channel 2.
    mem[8'h42] = 8'h33;
    mute_en    = 1'b1;
    mute_addr  = 8'h42;
    req_addr.delete();
    req_cyc.delete();
    wait_cond(1, 400, n);
    chk("tmo_done_seen", 64'(n > 0), 64'd1);
    chk("tmo_ch_tmo", 64'(ch_tmo), 64'h4);
    chk("tmo_ch_data", 64'(ch_data), 64'h40302110);
    chk("tmo_ch_vld", 64'(ch_vld), 64'hF);
    repeat (3) @(negedge sys_clk);
    chk("tmo_addrs", pack_addrs(0, 4), 64'h40414243);
    chk("tmo_gap", 64'(req_cyc[3] - req_cyc[2]), 64'd53);
    chk("tmo_no_overrun", 64'(overrun), 64'd0);
    mute_en    = 1'b0;
    mem[8'h42] = 8'h30;

    // Last STORE lands on the tick cycle: new scan starts, no overrun.
    eng_delay = 47;
    wait_cond(1, 400, n);
    chk("coin_done_seen", 64'(n > 0), 64'd1);
    wait_cond(0, 10, n);
    chk("coin_restart_lat", 64'(n), 64'd2);
    chk("coin_restart_addr", 64'(eng_reg_addr), 64'h40);
    chk("coin_no_overrun", 64'(overrun), 64'd0);
    @(negedge sys_clk);
    base = req_addr.size() - 1;

    // Overrun: slow engine, scans outlast the tick period.
    eng_delay = 60;
    wait_cond(3, 400, n);
    chk("ovr_seen", 64'(n > 0), 64'd1);
    for (int i = 0; i < 1000 && req_addr.size() < base + 8; i++) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovr_addr%0d", i), 64'(req_addr[base + i]), 64'(8'h40 + 8'(i % 4)));
    end
    wait_cond(1, 200, n);
    chk("ovr_done_seen", 64'(n > 0), 64'd1);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    chk("ovr_ch_tmo", 64'(ch_tmo), 64'hF);
    eng_delay = 3;

    // Channel 0 second sample.
    mem[8'h40] = 8'h13;
    wait_cond(1, 400, n);
    chk("avg_done_seen", 64'(n > 0), 64'd1);
    chk("avg_ch0", 64'(ch_data[7:0]), 64'(avg_exp));

    // Stray data pulse while idle is ignored.
    repeat (5) @(negedge sys_clk);
    stray_req++;
    repeat (3) @(negedge sys_clk);
    chk("stray_ch_data", 64'(ch_data), {32'h0, 24'h403021, avg_exp});
    chk("stray_host_ack", 64'(host_ack), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);

    // Reset during WAIT.
    wait_cond(0, 400, n);
    chk("rstw_req_addr", 64'(eng_reg_addr), 64'h40);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk_zero("rstw");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_cond(0, 400, n);
    chk("rstw_first_lat", 64'(n), 64'd201);
    chk("rstw_first_addr", 64'(eng_reg_addr), 64'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
